// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB control FSM sharing one
// req/ack memory port, with reset vector, illegal-opcode policy and request timeout.
module multicycle_cpu #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int unsigned WAIT_LIMIT      = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_out,
  output logic        retire,
  output logic        halted,
  output logic [1:0]  err_code
);

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrIllegal = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  logic [2:0]  state_q;
  logic        started_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] imm_q;
  logic [31:0] alu_q;
  logic [31:0] mdr_q;
  logic [31:0] wait_q;
  logic [31:0] rf_q [32];
  logic        retire_q;
  logic [1:0]  err_q;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];

  logic is_rtype, is_add, is_sub, is_slt, is_jr;
  logic is_addi, is_xori, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
  logic is_alu, legal;

  always_comb begin
    is_rtype = (opcode == OpRtype);
    is_add   = is_rtype && (funct == FnAdd);
    is_sub   = is_rtype && (funct == FnSub);
    is_slt   = is_rtype && (funct == FnSlt);
    is_jr    = is_rtype && (funct == FnJr);
    is_addi  = (opcode == OpAddi);
    is_xori  = (opcode == OpXori);
    is_lw    = (opcode == OpLw);
    is_sw    = (opcode == OpSw);
    is_beq   = (opcode == OpBeq);
    is_bne   = (opcode == OpBne);
    is_j     = (opcode == OpJ);
    is_jal   = (opcode == OpJal);
    // Ops that produce ALUout and continue to MEM or WB.
    is_alu   = is_add || is_sub || is_slt || is_addi || is_xori || is_lw || is_sw;
    legal    = is_alu || is_jr || is_beq || is_bne || is_j || is_jal;
  end

  logic [31:0] alu_res;

  always_comb begin
    alu_res = a_q + imm_q;
    if (is_add) begin
      alu_res = a_q + b_q;
    end else if (is_sub) begin
      alu_res = a_q - b_q;
    end else if (is_slt) begin
      alu_res = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
    end else if (is_xori) begin
      alu_res = a_q ^ {16'h0000, ir_q[15:0]};
    end
  end

  // Control-transfer target; pc_q already points at the following instruction here.
  logic [31:0] jump_pc;

  always_comb begin
    jump_pc = pc_q;
    if ((is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q))) begin
      jump_pc = pc_q + (imm_q << 2);
    end else if (is_j || is_jal) begin
      jump_pc = {pc_q[31:28], ir_q[25:0], 2'b00};
    end else if (is_jr) begin
      jump_pc = a_q;
    end
  end

  logic [4:0]  wb_dst;
  logic [31:0] wb_data;

  assign wb_dst  = is_rtype ? rd : rt;
  assign wb_data = is_lw ? mdr_q : alu_q;

  // started_q keeps the port idle during and immediately after reset.
  assign mem_req   = started_q && ((state_q == StFetch) || (state_q == StMem));
  assign mem_we    = mem_req && (state_q == StMem) && is_sw;
  assign mem_addr  = !mem_req ? 32'h0 : ((state_q == StFetch) ? pc_q : alu_q);
  assign mem_wdata = mem_we ? b_q : 32'h0;

  assign pc_out   = pc_q;
  assign retire   = retire_q;
  assign halted   = (state_q == StHalt);
  assign err_code = err_q;

  // An ack in the cycle the limit is reached wins over the timeout.
  logic timeout;

  assign timeout = (WAIT_LIMIT != 0) && mem_req && !mem_ack &&
                   ((wait_q + 32'd1) == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      started_q <= 1'b0;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      wait_q    <= '0;
      retire_q  <= 1'b0;
      err_q     <= ErrNone;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      started_q <= 1'b1;
      retire_q  <= 1'b0;
      wait_q    <= (mem_req && !mem_ack) ? wait_q + 32'd1 : '0;
      case (state_q)
        StFetch: begin
          if (mem_req) begin
            if (mem_ack) begin
              ir_q    <= mem_rdata;
              pc_q    <= pc_q + 32'd4;
              state_q <= StDecode;
            end else if (timeout) begin
              err_q   <= ErrTimeout;
              state_q <= StHalt;
            end
          end
        end
        StDecode: begin
          a_q   <= rf_q[rs];
          b_q   <= rf_q[rt];
          imm_q <= {{16{ir_q[15]}}, ir_q[15:0]};
          if (!legal && HALT_ON_ILLEGAL) begin
            err_q   <= ErrIllegal;
            state_q <= StHalt;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          if (is_alu) begin
            alu_q   <= alu_res;
            state_q <= (is_lw || is_sw) ? StMem : StWb;
          end else begin
            // Branches, jumps and tolerated illegal opcodes retire here.
            if (is_jal) begin
              rf_q[31] <= pc_q;
            end
            pc_q     <= jump_pc;
            retire_q <= 1'b1;
            state_q  <= StFetch;
          end
        end
        StMem: begin
          if (mem_ack) begin
            if (is_sw) begin
              retire_q <= 1'b1;
              state_q  <= StFetch;
            end else begin
              mdr_q   <= mem_rdata;
              state_q <= StWb;
            end
          end else if (timeout) begin
            err_q   <= ErrTimeout;
            state_q <= StHalt;
          end
        end
        StWb: begin
          if (wb_dst != 5'd0) begin
            rf_q[wb_dst] <= wb_data;
          end
          retire_q <= 1'b1;
          state_q  <= StFetch;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StFetch;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: a configurable-latency memory for the main core and a
// zero-wait ROM for a second core that treats illegal opcodes as NOPs.
module tb_multicycle_cpu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        mem_req, mem_we, mem_ack, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic [1:0]  err_code;

  logic        mem_req2, mem_we2, mem_ack2, retire2, halted2;
  logic [31:0] mem_addr2, mem_wdata2, mem_rdata2, pc_out2;
  logic [1:0]  err_code2;

  multicycle_cpu #(
    .RESET_PC        (32'h0000_0100),
    .HALT_ON_ILLEGAL (1'b1),
    .WAIT_LIMIT      (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .pc_out    (pc_out),
    .retire    (retire),
    .halted    (halted),
    .err_code  (err_code)
  );

  multicycle_cpu #(
    .RESET_PC        (32'h0000_0000),
    .HALT_ON_ILLEGAL (1'b0),
    .WAIT_LIMIT      (0)
  ) dut_nop (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_req   (mem_req2),
    .mem_we    (mem_we2),
    .mem_addr  (mem_addr2),
    .mem_wdata (mem_wdata2),
    .mem_ack   (mem_ack2),
    .mem_rdata (mem_rdata2),
    .pc_out    (pc_out2),
    .retire    (retire2),
    .halted    (halted2),
    .err_code  (err_code2)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mem  [256];
  logic [31:0] mem2 [64];
  logic [31:0] wmem [256];
  logic [255:0] wvalid = '0;
  int   delay     = 0;
  logic never_ack = 1'b0;
  logic clr       = 1'b1;
  int   wcnt      = 0;
  int   stab_err  = 0;
  logic p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [31:0] flog  [16];
  logic [31:0] flog2 [16];
  int   fn  = 0;
  int   fn2 = 0;

  assign mem_ack    = mem_req && !never_ack && (wcnt == delay);
  assign mem_rdata  = wvalid[mem_addr[9:2]] ? wmem[mem_addr[9:2]] : mem[mem_addr[9:2]];
  assign mem_ack2   = mem_req2;
  assign mem_rdata2 = mem2[mem_addr2[7:2]];

  // Memory responder, store capture, fetch log and request-stability monitor.
  always @(posedge clk) begin
    if (clr) begin
      wcnt     <= 0;
      wvalid   <= '0;
      fn       <= 0;
      fn2      <= 0;
      stab_err <= 0;
      p_req    <= 1'b0;
      p_ack    <= 1'b0;
    end else begin
      wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
      if (p_req && !p_ack && mem_req &&
          ((mem_addr !== p_addr) || (mem_we !== p_we) || (mem_wdata !== p_wdata))) begin
        stab_err <= stab_err + 1;
      end
      p_req   <= mem_req;
      p_ack   <= mem_ack;
      p_addr  <= mem_addr;
      p_we    <= mem_we;
      p_wdata <= mem_wdata;
      if (mem_req && mem_ack && mem_we) begin
        wmem[mem_addr[9:2]]   <= mem_wdata;
        wvalid[mem_addr[9:2]] <= 1'b1;
      end
      if (mem_req && mem_ack && !mem_we && fn < 16) begin
        flog[fn] <= mem_addr;
        fn       <= fn + 1;
      end
      if (mem_req2 && mem_ack2 && fn2 < 16) begin
        flog2[fn2] <= mem_addr2;
        fn2        <= fn2 + 1;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 64; i++) mem2[i] = 32'h0;
  endtask

  // Leaves the bench at a negedge with reset still asserted.
  task automatic apply_reset();
    reset_n = 1'b0;
    clr     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    clr     = 1'b0;
  endtask

  task automatic run_count(input int max_cyc, input int target,
                           output int c0, output int ct, output int nret);
    c0 = -1;
    ct = -1;
    nret = 0;
    for (int cyc = 1; cyc <= max_cyc && ct < 0; cyc++) begin
      @(negedge clk);
      if (c0 < 0 && mem_req) c0 = cyc;
      if (retire) begin
        nret++;
        if (nret == target) ct = cyc;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    clear_mem();
    mem[64] = 32'h2001_0005;  // addi $1,$0,5
    mem[65] = 32'h0800_0041;  // j 0x104
    delay = 0;
    never_ack = 1'b0;
    apply_reset();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: got %b expected 0", mem_req);
    end
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_we: got %b expected 0", mem_we);
    end
    checks++;
    if (mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h expected 0", mem_addr);
    end
    checks++;
    if (mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_wdata: got %h expected 0", mem_wdata);
    end
    checks++;
    if (retire !== 1'b0) begin
      errors++;
      $display("FAIL reset_retire: got %b expected 0", retire);
    end
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_halted: got %b expected 0", halted);
    end
    checks++;
    if (err_code !== 2'b00) begin
      errors++;
      $display("FAIL reset_err: got %b expected 00", err_code);
    end
    checks++;
    if (pc_out !== 32'h100) begin
      errors++;
      $display("FAIL reset_pc: got %h expected 100", pc_out);
    end
    release_reset();
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL first_fetch: got req=%b we=%b addr=%h expected req=1 we=0 addr=100",
               mem_req, mem_we, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (pc_out !== 32'h104) begin
      errors++;
      $display("FAIL pc_after_fetch: got %h expected 104", pc_out);
    end
  endtask

  task automatic test_program();
    int c0, ct, nr;
    clear_mem();
    mem[64] = 32'h2001_0005;  // addi $1,$0,5
    mem[65] = 32'h2002_FFFD;  // addi $2,$0,-3
    mem[66] = 32'h0022_1820;  // add  $3,$1,$2
    mem[67] = 32'h0041_202A;  // slt  $4,$2,$1
    mem[68] = 32'hAC03_0008;  // sw   $3,8($0)
    mem[69] = 32'h8C05_0008;  // lw   $5,8($0)
    mem[70] = 32'h0022_3822;  // sub  $7,$1,$2
    mem[71] = 32'h3826_FFFF;  // xori $6,$1,0xFFFF
    mem[72] = 32'h0800_0048;  // j 0x120
    delay = 0;
    never_ack = 1'b0;
    apply_reset();
    release_reset();
    run_count(100, 6, c0, ct, nr);
    checks++;
    if (nr != 6) begin
      errors++;
      $display("FAIL prog_retires: got %0d expected 6", nr);
    end
    checks++;
    if (ct - c0 != 25) begin
      errors++;
      $display("FAIL prog_cycles: got %0d expected 25", ct - c0);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (dut.rf_q[3] !== 32'd2) begin
      errors++;
      $display("FAIL add_r3: got %h expected 2", dut.rf_q[3]);
    end
    checks++;
    if (dut.rf_q[4] !== 32'd1) begin
      errors++;
      $display("FAIL slt_r4: got %h expected 1", dut.rf_q[4]);
    end
    checks++;
    if (!wvalid[2] || wmem[2] !== 32'd2) begin
      errors++;
      $display("FAIL sw_mem8: got valid=%b data=%h expected valid=1 data=2", wvalid[2], wmem[2]);
    end
    checks++;
    if (dut.rf_q[5] !== 32'd2) begin
      errors++;
      $display("FAIL lw_r5: got %h expected 2", dut.rf_q[5]);
    end
    checks++;
    if (dut.rf_q[7] !== 32'd8) begin
      errors++;
      $display("FAIL sub_r7: got %h expected 8", dut.rf_q[7]);
    end
    checks++;
    if (dut.rf_q[6] !== 32'h0000_FFFA) begin
      errors++;
      $display("FAIL xori_r6: got %h expected 0000fffa", dut.rf_q[6]);
    end
  endtask

  task automatic test_branch();
    int c0, ct, nr;
    logic [31:0] exp_f [5];
    exp_f[0] = 32'h100;
    exp_f[1] = 32'h10C;
    exp_f[2] = 32'h110;
    exp_f[3] = 32'h140;
    exp_f[4] = 32'h114;
    clear_mem();
    mem[64] = 32'h1000_0002;  // 0x100 beq $0,$0,+2
    mem[67] = 32'h1400_0002;  // 0x10C bne $0,$0,+2
    mem[68] = 32'h0C00_0050;  // 0x110 jal 0x140
    mem[80] = 32'h03E0_0008;  // 0x140 jr $31
    mem[69] = 32'h0800_0045;  // 0x114 j 0x114
    delay = 0;
    never_ack = 1'b0;
    apply_reset();
    release_reset();
    run_count(60, 4, c0, ct, nr);
    checks++;
    if (ct - c0 != 12) begin
      errors++;
      $display("FAIL branch_cycles: got %0d expected 12", ct - c0);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (fn < 5) begin
      errors++;
      $display("FAIL fetch_count: got %0d expected >=5", fn);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (flog[i] !== exp_f[i]) begin
        errors++;
        $display("FAIL fetch_seq[%0d]: got %h expected %h", i, flog[i], exp_f[i]);
      end
    end
    checks++;
    if (dut.rf_q[31] !== 32'h114) begin
      errors++;
      $display("FAIL jal_r31: got %h expected 114", dut.rf_q[31]);
    end
  endtask

  task automatic test_wait();
    int c0, ct, nr;
    clear_mem();
    mem[64] = 32'h2001_0005;  // addi $1,$0,5
    mem[65] = 32'hAC01_0010;  // sw   $1,16($0)
    mem[66] = 32'h0800_0042;  // j 0x108
    delay = 3;
    never_ack = 1'b0;
    apply_reset();
    release_reset();
    run_count(60, 1, c0, ct, nr);
    checks++;
    if (ct - c0 != 7) begin
      errors++;
      $display("FAIL wait_addi_cycles: got %0d expected 7", ct - c0);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (stab_err != 0) begin
      errors++;
      $display("FAIL req_stable: got %0d changes expected 0", stab_err);
    end
    checks++;
    if (!wvalid[4] || wmem[4] !== 32'd5) begin
      errors++;
      $display("FAIL wait_sw: got valid=%b data=%h expected valid=1 data=5", wvalid[4], wmem[4]);
    end
    checks++;
    if (halted !== 1'b0 || err_code !== 2'b00) begin
      errors++;
      $display("FAIL ack_wins_limit: got halted=%b err=%b expected 0 00", halted, err_code);
    end
  endtask

  task automatic test_timeout();
    int nreq, nret, n;
    clear_mem();
    delay = 0;
    never_ack = 1'b1;
    apply_reset();
    release_reset();
    nreq = 0;
    nret = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) nreq++;
      if (retire) nret++;
    end
    checks++;
    if (nreq != 4) begin
      errors++;
      $display("FAIL timeout_req_cycles: got %0d expected 4", nreq);
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL timeout_halted: got %b expected 1", halted);
    end
    checks++;
    if (err_code !== 2'b10) begin
      errors++;
      $display("FAIL timeout_err: got %b expected 10", err_code);
    end
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_req_low: got %b expected 0", mem_req);
    end
    checks++;
    if (pc_out !== 32'h100) begin
      errors++;
      $display("FAIL timeout_pc: got %h expected 100", pc_out);
    end
    checks++;
    if (nret != 0) begin
      errors++;
      $display("FAIL timeout_retire: got %0d expected 0", nret);
    end
    never_ack = 1'b0;
    apply_reset();
    checks++;
    if (halted !== 1'b0 || err_code !== 2'b00) begin
      errors++;
      $display("FAIL reset_clears_halt: got halted=%b err=%b expected 0 00", halted, err_code);
    end
    release_reset();
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL restart_fetch: got req=%b addr=%h expected req=1 addr=100", mem_req, mem_addr);
    end
  endtask

  task automatic test_illegal_halt();
    int nret;
    clear_mem();
    mem[64] = 32'hFC00_0000;  // opcode 0x3F
    delay = 0;
    never_ack = 1'b0;
    apply_reset();
    release_reset();
    nret = 0;
    repeat (15) begin
      @(negedge clk);
      if (retire) nret++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL illegal_halted: got %b expected 1", halted);
    end
    checks++;
    if (err_code !== 2'b01) begin
      errors++;
      $display("FAIL illegal_err: got %b expected 01", err_code);
    end
    checks++;
    if (nret != 0) begin
      errors++;
      $display("FAIL illegal_retire: got %0d expected 0", nret);
    end
    checks++;
    if (pc_out !== 32'h104) begin
      errors++;
      $display("FAIL illegal_pc: got %h expected 104", pc_out);
    end
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL illegal_req: got %b expected 0", mem_req);
    end
  endtask

  task automatic test_illegal_nop();
    int c0, r1;
    clear_mem();
    mem2[0] = 32'hFC00_0000;  // opcode 0x3F, tolerated
    mem2[1] = 32'h2000_0007;  // addi $0,$0,7
    mem2[2] = 32'h2002_0001;  // addi $2,$0,1
    mem2[3] = 32'h0800_0003;  // j 0xC
    apply_reset();
    release_reset();
    c0 = -1;
    r1 = -1;
    for (int cyc = 1; cyc <= 30 && r1 < 0; cyc++) begin
      @(negedge clk);
      if (c0 < 0 && mem_req2) c0 = cyc;
      if (retire2) r1 = cyc;
    end
    checks++;
    if (r1 - c0 != 3) begin
      errors++;
      $display("FAIL nop_retire_cycles: got %0d expected 3", r1 - c0);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (flog2[1] !== 32'h4) begin
      errors++;
      $display("FAIL nop_next_fetch: got %h expected 4", flog2[1]);
    end
    checks++;
    if (dut_nop.rf_q[2] !== 32'd1) begin
      errors++;
      $display("FAIL r0_reads_zero: got %h expected 1", dut_nop.rf_q[2]);
    end
    checks++;
    if (dut_nop.rf_q[0] !== 32'd0) begin
      errors++;
      $display("FAIL r0_unwritten: got %h expected 0", dut_nop.rf_q[0]);
    end
    checks++;
    if (halted2 !== 1'b0 || err_code2 !== 2'b00) begin
      errors++;
      $display("FAIL nop_no_halt: got halted=%b err=%b expected 0 00", halted2, err_code2);
    end
    checks++;
    if (mem_we2 !== 1'b0 || mem_wdata2 !== 32'h0 || pc_out2 > 32'h10) begin
      errors++;
      $display("FAIL nop_port_idle: got we=%b wdata=%h pc=%h expected 0 0 <=10",
               mem_we2, mem_wdata2, pc_out2);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_branch();
    test_wait();
    test_timeout();
    test_illegal_halt();
    test_illegal_nop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
- Multi-cycle successor to the single-cycle datapath. It executes the same MIPS subset from a single shared instruction/data memory port with a req/ack handshake.
- Each instruction passes through a control FSM (FETCH/DECODE/EXEC/MEM/WB) instead of completing in one cycle.
- Adds parametrised reset vector, illegal-opcode policy and memory-timeout detection, with halt/error status.
- Sits at CPU top level, replacing separate instruction and data memories with one external memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_ON_ILLEGAL, 1, 1 = undefined opcode/funct halts with error; 0 = treated as NOP (retired, no state change besides PC).
- WAIT_LIMIT, 0, max cycles mem_req may stay unacknowledged; 0 disables timeout.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write (SW), 0 = read.
- mem_addr  out  32  byte address, word aligned.
- mem_wdata  out  32  store data.
- mem_ack  in  1  request completed this cycle; mem_rdata valid when read.
- mem_rdata  in  32  read data.
- pc_out  out  32  current PC.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core stopped.
- err_code  out  2  00 none, 01 illegal instruction, 10 memory timeout.

Behaviour:
- Reset (reset_n low at a clk edge): state = FETCH; pc = RESET_PC; all 32 registers = 0; mem_req = mem_we = 0; mem_addr = mem_wdata = 0; retire = 0; halted = 0; err_code = 00; wait counter = 0.
  - Reset asserted mid-request drops mem_req at that edge.
  - An ack arriving in the reset cycle is ignored.
- Handshake:
  - mem_addr, mem_we and mem_wdata are held stable while mem_req is high.
  - Transfer completes at the first edge with mem_req & mem_ack.
  - mem_req deasserts in the following cycle.
  - mem_ack while mem_req is low is ignored.
- FETCH: mem_req = 1, mem_we = 0, mem_addr = pc. On ack: IR <= mem_rdata, pc <= pc + 4, go to DECODE.
- DECODE: A <= reg[rs], B <= reg[rt], imm <= sign-extended IR[15:0]. Go to EXEC; go to HALT if illegal and HALT_ON_ILLEGAL = 1.
- EXEC, by instruction:
  - R-type ADD (funct 0x20), SUB (0x22), SLT (0x2A, signed): ALUout <= result, go to WB.
  - ADDI (0x08): ALUout <= A + imm, go to WB.
  - XORI (0x0E): ALUout <= A ^ zero-extended IR[15:0], go to WB.
  - LW (0x23) / SW (0x2B): ALUout <= A + imm, go to MEM.
  - BEQ (0x04) / BNE (0x05): if taken, pc <= pc + (imm << 2), where pc is already +4. Retire, go to FETCH.
  - J (0x02): pc <= {pc[31:28], IR[25:0], 2'b00}. Retire, go to FETCH.
  - JAL (0x03): reg[31] <= pc (old pc + 4), then jump as J. Retire, go to FETCH.
  - JR (funct 0x08): pc <= A. Retire, go to FETCH.
  - Illegal instruction with HALT_ON_ILLEGAL = 0: retire, go to FETCH.
- MEM: mem_req = 1, mem_addr = ALUout, mem_we = (SW), mem_wdata = B.
  - On ack, SW: retire, go to FETCH.
  - On ack, LW: MDR <= mem_rdata, go to WB.
- WB: reg[rt or rd] <= ALUout or MDR. Retire, go to FETCH.
- Arithmetic: 32-bit, wrap-around; no overflow trap.
- Writes to $0 are discarded; $0 always reads 0.
- Latency with zero-wait memory (ack in first req cycle):
  - R/I-type ALU ops: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch/jump: 3 cycles.
  - Each memory wait cycle adds 1.
- retire is high for exactly the cycle after the retiring edge.
- Timeout (WAIT_LIMIT = N > 0):
  - Counter increments each cycle mem_req is high without ack, and clears on ack.
  - When it reaches N, drop mem_req, err_code = 10, go to HALT.
  - An ack in the same cycle the counter reaches N wins: the transfer completes and no error is raised.
- HALT: mem_req = 0, halted = 1, pc frozen, no retire. Only reset exits HALT.
- Illegal instruction with HALT_ON_ILLEGAL = 1: err_code = 01, pc = address of illegal instr + 4.

Test Plan:
- Reset with RESET_PC = 32'h100, zero-wait memory → first mem_addr = 32'h100; pc_out = 32'h104 after first fetch; all outputs at reset values during reset.
- Program "addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; sw $3,8($0); lw $5,8($0)" → $3 = 2, $4 = 1, mem[8] = 2, $5 = 2; 6 retire pulses in 4+4+4+4+4+5 = 25 cycles.
- "beq $0,$0,+2" at 0x0 → next fetch address 0x0C; "bne $0,$0,+2" → next fetch 0x04; "jal 0x40" at 0x20 → $31 = 0x24, next fetch 0x100; "jr $31" → next fetch 0x24.
- Memory acks after 3 wait cycles on every request → mem_addr/mem_we stable throughout; addi takes 7 cycles.
- WAIT_LIMIT = 4, memory never acks → mem_req high 4 cycles then low; halted = 1, err_code = 10. Assert reset_n low → fetch restarts at RESET_PC.
- Opcode 0x3F with HALT_ON_ILLEGAL = 1 → halted = 1, err_code = 01, no retire. With HALT_ON_ILLEGAL = 0 → retire pulse and next fetch at +4. "addi $0,$0,7" → $0 reads 0.
